// File: rtl/novacore_bitstream_streamer.sv
// novacore_bitstream_streamer: streams a contiguous run of words from the 16K x 32 bitstream RAM.
// Latency: first word valid two cycles after start is taken, then one word per cycle with out_ready high.
// Backpressure: out_ready low stalls the head word; FIFO credit throttles read issue so no return is lost.
// Optional feature: define NOVACORE_STREAMER_CHECKSUM_EN to build the running sum driven on checksum.

// novacore_streamer_fifo: small synchronous FIFO with flush.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the producer must never push into a full FIFO.
module novacore_streamer_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_pop   = head_vld && pop_rdy;

    // Storage write; contents need no reset because head_vld gates visibility
    always_ff @(posedge clk) begin
        if (push_vld && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({push_vld, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// novacore_bitstream_streamer: RAM read sequencer plus output FIFO.
// Latency: start taken -> first word at the head two cycles later; sustained 1 word/cycle.
// Backpressure: out_valid/out_ready; reads issue only while FIFO entries plus the in-flight read leave room.
module novacore_bitstream_streamer #(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic [31:0]       checksum
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } word_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   issued;
    logic              inflight;
    logic              inflight_last;
    logic              issue;
    logic              start_take;
    logic              credit;
    logic [CNT_W:0]    occ;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    word_t             push_word;
    word_t             head_word;

    // Entries already held plus the read whose data lands next edge must leave a free slot
    assign occ        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign credit     = occ < (CNT_W+1)'(FIFO_DEPTH);
    assign issue      = (state == FETCH) && (issued < count) && credit && !abort;
    assign start_take = (state == IDLE) && start && !abort;
    assign fifo_empty = (fifo_count == '0);

    assign mem_address    = addr;
    assign mem_chipselect = issue;
    assign mem_clken      = 1'b1;

    // The last-word tag travels with the read so out_last lines up with its data
    assign push_word.last = inflight_last;
    assign push_word.data = mem_readdata;

    novacore_streamer_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (abort),
        .push_vld (inflight),
        .push_dat (push_word),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (head_word),
        .count    (fifo_count)
    );

    assign out_data = head_word.data;
    assign out_last = out_valid && head_word.last;

    // Transfer sequencer: latch the request, issue reads under credit, wait for the FIFO to drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            count         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (issued == count - CNT_ONE);
            if (abort) begin
                // Abort beats everything: the pending return is dropped and no done is reported
                state    <= IDLE;
                inflight <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_take) begin
                            if (word_count != '0) begin
                                addr   <= start_addr;
                                count  <= word_count;
                                issued <= '0;
                                busy   <= 1'b1;
                                state  <= FETCH;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        if (issue) begin
                            addr   <= addr + ADDR_ONE;
                            issued <= issued + CNT_ONE;
                            if (issued + CNT_ONE == count) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (fifo_empty && !inflight) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef NOVACORE_STREAMER_CHECKSUM_EN
    logic [31:0] csum;

    // Running sum of accepted words, restarted by each accepted start and held afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (start_take) begin
            csum <= '0;
        end else if (out_valid && out_ready) begin
            csum <= csum + out_data;
        end
    end

    assign checksum = csum;
`else
    assign checksum = 32'd0;
`endif
endmodule

// File: doc/novacore_bitstream_streamer.md
Name: novacore_bitstream_streamer

Overview:
- Read-side consumer of the 16K x 32 bitstream on-chip RAM.
- On a start command it fetches a contiguous run of 32-bit words from the RAM and presents them on a valid/ready word stream to the downstream configuration/blaster logic.
- Absorbs the RAM's fixed 1-cycle read latency and downstream backpressure with a small FIFO.
- Sustains 1 word/cycle when the sink is ready.

Parameters:
- ADDR_W, 14, RAM word-address width (depth 2^ADDR_W = 16384).
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a transfer, ignored unless IDLE.
- start_addr  in  ADDR_W  first word address, sampled on start.
- word_count  in  ADDR_W+1  words to transfer (0..16384), sampled on start.
- abort  in  1  terminates any transfer in progress.
- busy  out  1  high from the cycle after an accepted start until the transfer ends.
- done  out  1  1-cycle pulse when the transfer completes normally.
- mem_address  out  ADDR_W  RAM read address.
- mem_chipselect  out  1  read-issue strobe (tie-through to RAM chipselect).
- mem_clken  out  1  constant 1.
- mem_readdata  in  32  RAM q; valid the cycle after issue.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink accepts the word.
- out_data  out  32  stream word.
- out_last  out  1  marks the final word of a transfer.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_last=0, checksum=0. FIFO empty, state IDLE.
- State machine states: IDLE, FETCH, DRAIN.
- IDLE:
  - start with word_count>0: latch addr and count, clear issued counter, go to FETCH.
  - start with word_count=0: done=1 on the next cycle, remain IDLE, busy stays 0.
- FETCH:
  - Issue one read per cycle (mem_chipselect=1, mem_address=current addr) while issued<count and fifo_count+inflight<FIFO_DEPTH.
  - inflight is the 1-bit flag "read issued last cycle".
  - After each issue, addr increments and wraps 2^ADDR_W-1 -> 0.
  - When the last read has been issued, go to DRAIN.
- DRAIN: when the FIFO is empty and inflight=0, pulse done for 1 cycle and return to IDLE. busy drops in the same cycle done pulses.
- Read return: mem_readdata is written into the FIFO unconditionally in the cycle after issue. The credit rule guarantees it never overflows.
- Stream handshake:
  - out_data/out_valid/out_last come from the FIFO head.
  - A word transfers when out_valid & out_ready.
  - Once out_valid is high, the word is held stable until accepted.
  - Simultaneous push and pop in one cycle is legal and leaves fifo_count unchanged.
- out_last is asserted on exactly the word whose ordinal equals count (tagged at FIFO write).
- Throughput: with out_ready held high, the first word is valid 2 cycles after start, then 1 word/cycle, no bubbles.
- abort (any state, highest priority):
  - Next cycle: IDLE, FIFO flushed, out_valid=0.
  - Any in-flight read return is discarded.
  - No done pulse; busy=0.
- start coincident with abort: abort wins and start is ignored.
- start while busy is ignored.
- Asynchronous reset mid-transfer: identical to abort plus all outputs return to their reset values immediately.

Optional Feature:
- Macro: NOVACORE_STREAMER_CHECKSUM_EN.
- Defined:
  - checksum = 32-bit modulo-2^32 sum of every word accepted on the stream (out_valid & out_ready).
  - Cleared to 0 on an accepted start; held after done or abort until the next start.
- Undefined: checksum is driven constant 0 and no accumulator logic is built.

Test Plan:
- Basic run: RAM[0x10..0x13]=1,2,3,4; start_addr=0x10, word_count=4, out_ready=1.
  -> Words 1,2,3,4 on consecutive cycles; out_last only on 4; done 1 cycle after the last transfer completes; checksum=10 with macro, 0 without.
- Wrap: start_addr=0x3FFE, word_count=4.
  -> Addresses issued 0x3FFE, 0x3FFF, 0x0000, 0x0001 in order.
- Backpressure: word_count=8, out_ready toggling 1/0 each cycle.
  -> All 8 words in order, none lost or duplicated, fifo_count never exceeds 4, out_data stable while stalled.
- Zero length: start with word_count=0.
  -> done pulse next cycle, mem_chipselect never asserted, busy stays 0.
- Abort: word_count=100, out_ready=0, abort asserted 10 cycles after start.
  -> Next cycle IDLE with out_valid=0 and busy=0, no done pulse. A new start then streams correctly from its own start_addr.
- Start while busy: second start during a 16-word transfer.
  -> Ignored; exactly 16 words delivered and a single done pulse.
